// File: rtl/qupls_bitfield_fu.sv
// Pipelined bitfield functional unit: E1 operand register, combinational CLR/SET/COM/EXTU/EXTS/DEP
// evaluation, and an in-order result queue. Define QUPLS_BF_SKID_EN for a 2-entry queue that removes wb_rdy->issue_rdy.
module qupls_bitfield_fu #(
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_v,
  output logic            issue_rdy,
  input  logic [39:0]     issue_ir,
  input  logic [TAGW-1:0] issue_tag,
  input  logic [63:0]     issue_t,
  input  logic [63:0]     issue_a,
  input  logic [63:0]     issue_b,
  input  logic [63:0]     issue_c,
  output logic            wb_v,
  input  logic            wb_rdy,
  output logic [TAGW-1:0] wb_tag,
  output logic [63:0]     wb_res,
  output logic            wb_exc,
  output logic            busy
);

  localparam int unsigned W = 64;

  typedef enum logic [6:0] {
    OP_CLR  = 7'h50,
    OP_SET  = 7'h51,
    OP_COM  = 7'h52,
    OP_EXTU = 7'h53,
    OP_EXTS = 7'h54,
    OP_DEP  = 7'h55
  } bf_op_e;

`ifdef QUPLS_BF_SKID_EN
  localparam logic [1:0] QD   = 2'd2;
  localparam logic       PMAX = 1'b1;
`else
  localparam logic [1:0] QD   = 2'd1;
  localparam logic       PMAX = 1'b0;
`endif

  logic [39:0]     r_ir;
  logic [TAGW-1:0] r_tag;
  logic [W-1:0]    r_t, r_a, r_b, r_c;
  logic            r_e1_v;

  logic [TAGW-1:0] r_q_tag [2];
  logic [W-1:0]    r_q_res [2];
  logic            r_q_exc [2];
  logic            r_wr, r_rd;
  logic [1:0]      r_cnt;

  logic [6:0]      w_mb, w_me;
  logic [5:0]      w_sh, w_nsh, w_sp;
  logic [W-1:0]    w_mask, w_ext, w_dep, w_fill, w_res;
  logic [2*W-1:0]  w_rot_ext, w_rot_dep;
  logic            w_exc, w_sign;
  logic            w_hs, w_push, w_pop;
  logic            w_unused;

  assign w_unused = ^{r_ir[39:34], r_ir[18:7], r_b[63:7], r_c[63:7]};

  assign w_mb  = r_ir[33] ? r_ir[25:19] : r_b[6:0];
  assign w_me  = r_ir[33] ? r_ir[32:26] : r_c[6:0];
  assign w_sh  = w_mb[5:0];
  assign w_nsh = 6'd0 - w_sh;
  assign w_sp  = w_me[5:0] - w_mb[5:0];

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (w_mb <= w_me) w_mask[i] = (7'(i) >= w_mb) && (7'(i) <= w_me);
      else              w_mask[i] = (7'(i) >= w_mb) || (7'(i) <= w_me);
    end
  end

  // Extract rotates the masked field down to bit 0; a wrapped field comes out contiguous.
  // Deposit rotates the source up by mb so its low bits land on the field.
  always_comb begin
    w_rot_ext = {r_a & w_mask, r_a & w_mask} >> w_sh;
    w_ext     = w_rot_ext[W-1:0];
    w_rot_dep = {r_a, r_a} >> w_nsh;
    w_dep     = (r_t & ~w_mask) | (w_rot_dep[W-1:0] & w_mask);
    w_sign    = w_ext[w_sp];
    w_fill    = ~((64'd2 << w_sp) - 64'd1);
    w_res     = '0;
    w_exc     = 1'b0;
    case (r_ir[6:0])
      OP_CLR:  w_res = r_a & ~w_mask;
      OP_SET:  w_res = r_a | w_mask;
      OP_COM:  w_res = r_a ^ w_mask;
      OP_EXTU: w_res = w_ext;
      OP_EXTS: w_res = w_ext | (w_sign ? w_fill : '0);
      OP_DEP:  w_res = w_dep;
      default: w_exc = 1'b1;
    endcase
  end

  assign wb_v   = (r_cnt != 2'd0) & ~flush;
  assign wb_tag = r_q_tag[r_rd];
  assign wb_res = r_q_res[r_rd];
  assign wb_exc = r_q_exc[r_rd];
  assign busy   = r_e1_v | (r_cnt != 2'd0);

`ifdef QUPLS_BF_SKID_EN
  assign issue_rdy = ~rst & ~flush & (~r_e1_v | (r_cnt < QD));
`else
  assign issue_rdy = ~rst & ~flush & (~r_e1_v | (r_cnt == 2'd0) | wb_rdy);
`endif

  assign w_hs   = issue_v & issue_rdy;
  assign w_pop  = wb_v & wb_rdy;
  assign w_push = r_e1_v & ((r_cnt < QD) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir   <= '0;
      r_tag  <= '0;
      r_t    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_e1_v <= 1'b0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_cnt  <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        r_q_tag[k] <= '0;
        r_q_res[k] <= '0;
        r_q_exc[k] <= 1'b0;
      end
    end else if (flush) begin
      r_e1_v <= 1'b0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_hs) begin
        r_ir  <= issue_ir;
        r_tag <= issue_tag;
        r_t   <= issue_t;
        r_a   <= issue_a;
        r_b   <= issue_b;
        r_c   <= issue_c;
      end
      r_e1_v <= w_hs | (r_e1_v & ~w_push);
      if (w_push) begin
        r_q_tag[r_wr] <= r_tag;
        r_q_res[r_wr] <= w_res;
        r_q_exc[r_wr] <= w_exc;
        r_wr          <= (r_wr == PMAX) ? 1'b0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == PMAX) ? 1'b0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: doc/qupls_bitfield_fu.md
# qupls_bitfield_fu

Pipelined bitfield functional unit wrapper for the Qupls out-of-order core. Sits between the issue/operand-capture stage and the result writeback bus. Registers an issued bitfield instruction, evaluates it with the team's combinational bitfield core (CLR/SET/COM/EXTU/EXTS/DEP), and holds results in a small output queue until the writeback arbiter accepts them. Provides valid/ready backpressure on both sides and a pipeline flush.

## Interface
- TAGW, 5, width of ROB/result tag carried with each op
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill all in-flight and queued ops (branch miss / exception)
- issue_v  in  1  issue slot holds a valid bitfield op
- issue_rdy  out  1  unit can accept an op this cycle
- issue_ir  in  instruction_t  instruction word (opcode, ir[33] imm select, ir[25:19] mb, ir[32:26] me)
- issue_tag  in  TAGW  result tag
- issue_t, issue_a, issue_b, issue_c  in  value_t each  target-old, source, mb-reg, me-reg operands
- wb_v  out  1  result available
- wb_rdy  in  1  writeback bus accepts result
- wb_tag  out  TAGW  tag of presented result
- wb_res  out  value_t  result value
- wb_exc  out  1  opcode not a bitfield op
- busy  out  1  any op held in E1 or output queue

## Operation
- Stage E1: register set {ir, tag, t, a, b, c, e1_v}. Loads on issue handshake (issue_v & issue_rdy).
- Evaluation: bitfield core driven combinationally from E1 registers. mb = ir[33] ? ir[25:19] : b[6:0]; me = ir[33] ? ir[32:26] : c[6:0]; 7-bit, unsigned. me < mb selects wrap-around mask (bits mb..W-1 and 0..me).
- Legal opcodes: OP_CLR, OP_SET, OP_COM, OP_EXTU, OP_EXTS, OP_DEP. Any other: wb_exc=1, wb_res=0; still retires through queue in order.
- Output queue: FIFO, depth D, entries {tag, res, exc}. Push when e1_v & (cnt < D | pop). Pop when wb_v & wb_rdy. Push and pop in same cycle: cnt unchanged.
- e1_v next = issue handshake | (e1_v & !push).
- Strict in-order: results leave in issue order; no drop, no duplicate.
- wb_v = (cnt != 0) & !flush; wb_tag/res/exc = queue head.
- flush: at next edge e1_v=0, cnt=0, pointers reset. Issue presented in flush cycle is discarded. issue_rdy=0 during flush cycle.
- busy = e1_v | (cnt != 0).

## Timing
- Reset (rst high at edge): e1_v=0, cnt=0, pointers=0, queue payload=0. Outputs: wb_v=0, wb_tag=0, wb_res=0, wb_exc=0, busy=0; issue_rdy=0 while rst high, 1 first cycle after.
- Latency: op accepted at edge N -> wb_v high in cycle N+1 after edge N+1 (2 edges issue-to-writeback) with empty queue.
- Throughput: 1 op/clk while wb_rdy high.
- Reset or flush mid-operation: all in-flight work lost, no partial results emerge.
- rst has priority over flush; flush has priority over issue.

## Configuration
- QUPLS_BF_SKID_EN defined: D=2; issue_rdy = !rst & !flush & (!e1_v | cnt < 2). issue_rdy has no combinational path from wb_rdy; full throughput sustained (steady state cnt=1).
- Undefined: D=1; issue_rdy = !rst & !flush & (!e1_v | cnt==0 | wb_rdy). Combinational wb_rdy->issue_rdy path; full throughput only while wb_rdy high.
- All other behaviour identical.

## Test plan
- Reset: rst high 2 cycles with issue_v=1 -> no accept, wb_v=0, busy=0; cycle after release issue_rdy=1.
- OP_SET, imm, a=0, mb=4, me=7, tag=3 -> two edges later wb_v=1, wb_res=0xF0, wb_tag=3, wb_exc=0.
- OP_CLR wrap, a=all ones, mb=W-2, me=1 -> wb_res all ones except bits W-1, W-2, 1, 0 (W=64: 0x3FFF_FFFF_FFFF_FFFC).
- Backpressure: wb_rdy=0, issue tags 1..5 back-to-back -> issue_rdy drops after D+1 accepts; raise wb_rdy -> tags emerge 1..5 in order, none lost/duplicated, 1/clk.
- Flush with E1 and queue full -> next cycle wb_v=0, busy=0; op issued in flush cycle never appears; next issue (tag 9) returns normally.
- Illegal opcode, tag=7 -> wb_v with wb_exc=1, wb_res=0, wb_tag=7; following legal op returns wb_exc=0.
